// File: rtl/l1_pkg.sv
// Shared types and constants for the L1 refill controller.
//   word_t         : one memory/CPU word
//   block_t        : one assembled cache block, word k at [32k+31:32k]
//   refill_state_t : refill FSM states
package l1_pkg;

  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned WORDS_PER_BLOCK   = 4;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned BLOCK_W           = WORD_W * WORDS_PER_BLOCK;
  localparam int unsigned IDX_W             = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DELIVER
  } refill_state_t;

  // Word-aligned address of word k inside the block containing base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input idx_t k);
    return {base[ADDR_W-1:BLOCK_OFFSET_BITS], k, 2'b00};
  endfunction

endpackage

// File: rtl/l1_refill_buffer.sv
// Block assembly register: 4 x 32-bit slots written one word at a time.
// Ports:
//   clk, rst   : clock, async active-low reset (clears the block)
//   clear      : synchronous clear at the start of a new fill
//   wr_en      : write data into slot
//   slot, data : slot index and word to write
//   block      : assembled block
module l1_refill_buffer
  import l1_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   wr_en,
  input  idx_t   slot,
  input  word_t  data,
  output block_t block
);

  // Each word lands in its natural slot regardless of fetch order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block <= '0;
    end else if (clear) begin
      block <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) begin
        if (slot == idx_t'(i)) block[i*WORD_W +: WORD_W] <= data;
      end
    end
  end

endmodule

// File: rtl/l1_refill_ctrl.sv
// L1 miss handler: on a load miss, fetches the 128-bit block word-serially
// from main memory, assembles it and presents it to L1 with a one-cycle
// delivered pulse, stalling the CPU until the fill completes.
// Optional build macro: L1_REFILL_CRITICAL_WORD_FIRST_EN
//   defined   -> fetch starts at req_addr[3:2] and wraps
//   undefined -> fetch order is always 0,1,2,3
// Ports:
//   clk, rst             : clock, async active-low reset
//   req_valid, req_addr  : CPU load request
//   hit                  : L1 hit for the current lookup
//   stall                : combinational CPU stall
//   fill_addr            : L1 read address (req_addr when idle, latched during fill)
//   mem_req, mem_addr    : memory word read request / word-aligned address
//   mem_ack, mem_rdata   : memory word response
//   delivered, blockin   : one-cycle block-valid pulse and assembled block
module l1_refill_ctrl
  import l1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              hit,
  output logic              stall,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  word_t             mem_rdata,
  output logic              delivered,
  output block_t            blockin
);

  refill_state_t     state, state_d;
  idx_t              k, k_d;
  idx_t              ack_cnt, ack_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              delivered_d;
  logic              buf_clear;
  logic              buf_wr;
  logic              miss;
  idx_t              start_k;
  idx_t              k_inc;

  assign miss  = req_valid && !hit;
  assign k_inc = k + idx_t'(1);

`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_k = req_addr[BLOCK_OFFSET_BITS-1:2];
`else
  assign start_k = '0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      ack_cnt   <= '0;
      addr_q    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      delivered <= 1'b0;
    end else begin
      state     <= state_d;
      k         <= k_d;
      ack_cnt   <= ack_cnt_d;
      addr_q    <= addr_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      delivered <= delivered_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    k_d         = k;
    ack_cnt_d   = ack_cnt;
    addr_d      = addr_q;
    mem_req_d   = mem_req;
    mem_addr_d  = mem_addr;
    delivered_d = 1'b0;
    buf_clear   = 1'b0;
    buf_wr      = 1'b0;

    unique case (state)
      IDLE: begin
        if (miss) begin
          state_d    = FETCH;
          addr_d     = req_addr;
          k_d        = start_k;
          ack_cnt_d  = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = word_addr(req_addr, start_k);
          buf_clear  = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          buf_wr    = 1'b1;
          k_d       = k_inc;
          ack_cnt_d = ack_cnt + idx_t'(1);
          // Completion is counted on acks, independent of the start word.
          if (ack_cnt == idx_t'(WORDS_PER_BLOCK - 1)) begin
            state_d     = DELIVER;
            mem_req_d   = 1'b0;
            delivered_d = 1'b1;
          end else begin
            mem_addr_d = word_addr(addr_q, k_inc);
          end
        end
      end
      DELIVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall     = (state != IDLE) || miss;
  assign fill_addr = (state == IDLE) ? req_addr : addr_q;

  l1_refill_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (buf_clear),
    .wr_en (buf_wr),
    .slot  (k),
    .data  (mem_rdata),
    .block (blockin)
  );

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Scoreboard bench for l1_refill_ctrl: stimulus pushes expected memory
// addresses and blocks; a monitor pops and compares on mem_ack / delivered.
module tb_l1_refill_ctrl;
  import l1_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              hit;
  logic              stall;
  logic [ADDR_W-1:0] fill_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  word_t             mem_rdata;
  logic              delivered;
  block_t            blockin;

  int n_checks = 0;
  int n_fail   = 0;
  int acks_seen = 0;
  int lat[4];
  logic [31:0] data_base;
  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_block_q[$];

  always #5 clk = ~clk;

  l1_refill_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .hit       (hit),
    .stall     (stall),
    .fill_addr (fill_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .delivered (delivered),
    .blockin   (blockin)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Memory model: acks lat[slot] cycles after the request is first seen.
  initial begin
    int wait_cnt;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst && mem_req) begin
        if (wait_cnt >= lat[mem_addr[3:2]]) begin
          mem_ack   = 1'b1;
          mem_rdata = data_base + 32'(mem_addr[3:2]);
          wait_cnt  = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_req, prev_ack, prev_del;
    logic [31:0] prev_addr;
    prev_req = 1'b0; prev_ack = 1'b0; prev_del = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_req) check("stall_during_fill", stall, 1'b1);
      if (mem_req && prev_req && !prev_ack) check("mem_addr_hold", mem_addr, prev_addr);
      if (mem_req && mem_ack) begin
        acks_seen++;
        if (exp_addr_q.size() == 0) fail_now("unexpected_mem_ack");
        else check("mem_addr_seq", mem_addr, exp_addr_q.pop_front());
      end
      if (prev_del) check("delivered_one_cycle", delivered, 1'b0);
      if (delivered) begin
        if (exp_block_q.size() == 0) fail_now("unexpected_delivered");
        else check("blockin", blockin, exp_block_q.pop_front());
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_del  = delivered;
      prev_addr = mem_addr;
    end
  end

  function automatic int start_word(input logic [31:0] addr);
`ifdef L1_REFILL_CRITICAL_WORD_FIRST_EN
    return int'(addr[3:2]);
`else
    return 0;
`endif
  endfunction

  task automatic push_expect(input logic [31:0] addr, input logic [31:0] base);
    int s;
    s = start_word(addr);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back({addr[31:4], 2'(s + i), 2'b00});
    exp_block_q.push_back({base + 32'd3, base + 32'd2, base + 32'd1, base});
  endtask

  // Issue a miss, wait for delivery, then let L1 hit so the stall releases.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int exp_lat);
    int  cyc;
    bit  got;
    push_expect(addr, base);
    data_base = base;
    req_addr  = addr;
    req_valid = 1'b1;
    hit       = 1'b0;
    #1;
    check("stall_on_miss", stall, 1'b1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      #3;
      cyc++;
      if (delivered) got = 1'b1;
    end
    if (!got) fail_now("timeout_waiting_delivered");
    else check("fill_latency", cyc, exp_lat);
    hit = 1'b1;
    @(negedge clk);
    #3;
    check("stall_release_on_hit", stall, 1'b0);
    check("no_refetch_on_hit", mem_req, 1'b0);
    req_valid = 1'b0;
    hit       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, cyc;
    lat       = '{1, 1, 1, 1};
    data_base = 32'hA0;
    req_valid = 1'b0;
    req_addr  = '0;
    hit       = 1'b0;
    rst       = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_delivered", delivered, 1'b0);
    check("reset_blockin", blockin, 128'h0);
    check("reset_stall", stall, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #3;

    // Hit path: no fill, no stall.
    req_valid = 1'b1; hit = 1'b1; req_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hit_stall", stall, 1'b0);
      check("hit_mem_req", mem_req, 1'b0);
      check("hit_fill_addr", fill_addr, 32'h100);
      @(negedge clk);
      #3;
    end
    req_valid = 1'b0; hit = 1'b0;

    // In-order fill (or critical-word-first from word 1 when enabled).
    do_miss(32'h1234, 32'hA0, 9);

    // Backpressure on slot 2, with req_addr disturbed mid-fill.
    lat[2] = 5;
    fork
      do_miss(32'h1234, 32'hA0, 13);
      begin
        repeat (3) @(negedge clk);
        #4;
        check("fill_addr_latched", fill_addr, 32'h1234);
        req_addr = 32'h5550;
      end
    join
    lat[2] = 1;

    // Reset mid-fill after two acks.
    push_expect(32'h1234, 32'hC0);
    data_base = 32'hC0;
    req_addr  = 32'h1234; req_valid = 1'b1; hit = 1'b0;
    a0 = acks_seen;
    cyc = 0;
    while (acks_seen < a0 + 2 && cyc < 100) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    if (acks_seen < a0 + 2) fail_now("timeout_waiting_acks");
    rst = 1'b0;
    #1;
    check("midreset_mem_req", mem_req, 1'b0);
    check("midreset_delivered", delivered, 1'b0);
    check("midreset_blockin", blockin, 128'h0);
    check("midreset_stall_miss", stall, 1'b1);
    exp_addr_q.delete();
    exp_block_q.delete();
    req_valid = 1'b0;
    #1;
    check("midreset_stall_idle", stall, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #3;
      check("post_reset_mem_req", mem_req, 1'b0);
      check("post_reset_delivered", delivered, 1'b0);
    end
    do_miss(32'h2000, 32'hB0, 9);

    // Start word 2 (reordered only when critical-word-first is enabled).
    do_miss(32'h1238, 32'hA0, 9);

    repeat (3) @(negedge clk);
    #3;
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("block_queue_drained", 32'(exp_block_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
